// File: rtl/emtf_sort_pkg.sv
// Shared types and helpers for the EMTF sector sorters.
// Candidate widths (BWR rank bits, BPOW+1 key-ph bits) are fixed here so that
// every sorter stage exchanging cand_t agrees on the layout.
package emtf_sort_pkg;

  localparam int BWR    = 7;
  localparam int BPOW   = 7;
  localparam int N_ZONE = 4;
  localparam int N_SLOT = 3;
  localparam int N_CAND = N_ZONE * N_SLOT;
  localparam int N_BEST = 3;

  typedef struct packed {
    logic [BWR-1:0] rank;
    logic [BPOW:0]  ph;
    logic [1:0]     zone;
    logic [1:0]     slot;
  } cand_t;

  // Flat candidate index zone*3+slot, range 0..11.
  function automatic logic [3:0] flat_idx(cand_t c);
    return ({2'b00, c.zone} * 4'd3) + {2'b00, c.slot};
  endfunction

  // Strict ordering used for the sector ranking: higher rank wins, the lower
  // flat index breaks ties, so no two distinct candidates ever compare equal.
  function automatic logic beats(cand_t a, cand_t b);
    return (a.rank > b.rank) || ((a.rank == b.rank) && (flat_idx(a) < flat_idx(b)));
  endfunction

endpackage

// File: rtl/best3_select.sv
// Picks the three best of 12 candidates in two registered stages:
// a pairwise win matrix, then a win-count decode into a one-hot winner mux.
// Candidates must carry distinct zone/slot so win counts are unique.
module best3_select
  import emtf_sort_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  cand_t [N_CAND-1:0]     cand_i,
  output cand_t [N_BEST-1:0]     best_o,
  output logic  [N_BEST-1:0]     best_vld_o
);

  logic  [N_CAND-1:0][N_CAND-1:0] win_d;
  logic  [N_CAND-1:0][N_CAND-1:0] win_p2_q;
  cand_t [N_CAND-1:0]             cand_p2_q;
  logic  [N_CAND-1:0][3:0]        cnt;
  cand_t [N_BEST-1:0]             best_d;
  logic  [N_BEST-1:0]             vld_d;
  cand_t [N_BEST-1:0]             best_p3_q;
  logic  [N_BEST-1:0]             vld_p3_q;

  function automatic logic [3:0] popcnt12(logic [N_CAND-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_CAND; i++) c = c + 4'(v[i]);
    return c;
  endfunction

  // Row i of the matrix marks every candidate that candidate i beats.
  always_comb begin
    win_d = '0;
    for (int i = 0; i < N_CAND; i++)
      for (int j = 0; j < N_CAND; j++)
        if (i != j) win_d[i][j] = beats(cand_i[i], cand_i[j]);
  end

  // ---- stage 2 boundary: win matrix and candidate data ----
  always_ff @(posedge clk) begin
    if (rst) begin
      win_p2_q  <= '0;
      cand_p2_q <= '0;
    end else begin
      win_p2_q  <= win_d;
      cand_p2_q <= cand_i;
    end
  end

  // Number of opponents each candidate beats; the overall best beats all 11.
  always_comb begin
    for (int i = 0; i < N_CAND; i++) cnt[i] = popcnt12(win_p2_q[i]);
  end

  // Output k takes the unique candidate with 11-k wins; empty winners are zeroed.
  always_comb begin
    best_d = '0;
    vld_d  = '0;
    for (int k = 0; k < N_BEST; k++) begin
      for (int i = 0; i < N_CAND; i++)
        if (cnt[i] == 4'(N_CAND - 1 - k)) best_d[k] = best_d[k] | cand_p2_q[i];
      vld_d[k] = (best_d[k].rank != '0);
      if (!vld_d[k]) best_d[k] = '0;
    end
  end

  // ---- stage 3 boundary: registered winners ----
  always_ff @(posedge clk) begin
    if (rst) begin
      best_p3_q <= '0;
      vld_p3_q  <= '0;
    end else begin
      best_p3_q <= best_d;
      vld_p3_q  <= vld_d;
    end
  end

  assign best_o     = best_p3_q;
  assign best_vld_o = vld_p3_q;

endmodule

// File: rtl/sector_best3.sv
// Sector-level best-3 track selection from 4 zones x 3 sorted candidates.
// Three-clock pipeline: cross-zone ghost cancellation, win matrix, winner mux.
// Compile-time option GHOST_CANCEL_EN: when defined, stage 1 kills the weaker
// of two nearby candidates in different zones; when undefined, stage 1 is a
// plain register and GHOST_WIN has no effect.
module sector_best3
  import emtf_sort_pkg::*;
#(
  parameter int GHOST_WIN = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  input  logic [N_ZONE-1:0][N_SLOT-1:0][BPOW:0]   ph_num,
  input  logic [N_ZONE-1:0][N_SLOT-1:0][BWR-1:0]  ph_q,
  output logic [N_BEST-1:0][BWR-1:0]              best_q,
  output logic [N_BEST-1:0][BPOW:0]               best_ph,
  output logic [N_BEST-1:0][1:0]                  best_zone,
  output logic [N_BEST-1:0][1:0]                  best_slot,
  output logic [N_BEST-1:0]                       best_vld,
  output logic                                    out_valid
);

  cand_t [N_CAND-1:0] cand_in;
  cand_t [N_CAND-1:0] cand_d;
  cand_t [N_CAND-1:0] cand_p1_q;
  logic               vld_p1_q;
  logic               vld_p2_q;
  logic               vld_p3_q;
  cand_t [N_BEST-1:0] best_c;
  logic  [N_BEST-1:0] best_vld_c;

  // Tag every input candidate with its origin so it stays traceable downstream.
  always_comb begin
    for (int z = 0; z < N_ZONE; z++)
      for (int s = 0; s < N_SLOT; s++) begin
        cand_in[z*N_SLOT+s].rank = ph_q[z][s];
        cand_in[z*N_SLOT+s].ph   = ph_num[z][s];
        cand_in[z*N_SLOT+s].zone = 2'(z);
        cand_in[z*N_SLOT+s].slot = 2'(s);
      end
  end

`ifdef GHOST_CANCEL_EN
  // One extra bit of headroom keeps the subtraction free of wrap-around.
  localparam int              DW  = BPOW + 2;
  localparam logic [DW-1:0]   WIN = DW'(GHOST_WIN);

  // True when candidate a cancels candidate b as its ghost.
  function automatic logic ghost_kills(cand_t a, cand_t b);
    logic [DW-1:0] pa, pb, mag;
    pa  = DW'(a.ph);
    pb  = DW'(b.ph);
    mag = (pa >= pb) ? (pa - pb) : (pb - pa);
    return (a.rank != '0) && (b.rank != '0) && (mag <= WIN) &&
           ((a.rank > b.rank) || ((a.rank == b.rank) && (a.zone < b.zone)));
  endfunction

  // Kill decisions look only at the original ranks, so chains are not iterated.
  always_comb begin
    cand_d = cand_in;
    for (int i = 0; i < N_CAND; i++)
      for (int j = 0; j < N_CAND; j++)
        if (((i / N_SLOT) != (j / N_SLOT)) && ghost_kills(cand_in[j], cand_in[i]))
          cand_d[i].rank = '0;
  end
`else
  logic unused_ghost_win;
  assign unused_ghost_win = (GHOST_WIN != 0);

  // Ghosts pass through untouched; the stage is kept to hold latency constant.
  always_comb cand_d = cand_in;
`endif

  // ---- stage 1 boundary: ghost-cancelled candidates ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      cand_p1_q <= cand_d;
      vld_p1_q  <= in_valid;
    end
  end

  // Valid follows the data through stages 2 and 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  best3_select u_select (
    .clk        (clk),
    .rst        (rst),
    .cand_i     (cand_p1_q),
    .best_o     (best_c),
    .best_vld_o (best_vld_c)
  );

  // Split the winner structs onto the flat output buses.
  always_comb begin
    for (int k = 0; k < N_BEST; k++) begin
      best_q[k]    = best_c[k].rank;
      best_ph[k]   = best_c[k].ph;
      best_zone[k] = best_c[k].zone;
      best_slot[k] = best_c[k].slot;
    end
  end

  assign best_vld  = best_vld_c;
  assign out_valid = vld_p3_q;

endmodule

// File: tb/tb_sector_best3.sv
// Scoreboard bench for sector_best3: a reference model computes the expected
// sector winners when each set is driven; results are compared 3 clocks later.
module tb_sector_best3;

  localparam int GHOST_WIN = 4;

  typedef struct {
    bit              ov;
    bit              chk;
    logic [2:0][6:0] q;
    logic [2:0][7:0] ph;
    logic [2:0][1:0] z;
    logic [2:0][1:0] s;
    logic [2:0]      v;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic [3:0][2:0][7:0]  ph_num;
  logic [3:0][2:0][6:0]  ph_q;
  logic [2:0][6:0]       best_q;
  logic [2:0][7:0]       best_ph;
  logic [2:0][1:0]       best_zone;
  logic [2:0][1:0]       best_slot;
  logic [2:0]            best_vld;
  logic                  out_valid;

  exp_t  sb[$];
  int    n_chk = 0;
  int    n_err = 0;
  string cur   = "init";

  always #5 clk = ~clk;

  sector_best3 #(.GHOST_WIN(GHOST_WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .ph_num    (ph_num),
    .ph_q      (ph_q),
    .best_q    (best_q),
    .best_ph   (best_ph),
    .best_zone (best_zone),
    .best_slot (best_slot),
    .best_vld  (best_vld),
    .out_valid (out_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference: explicit ghost scan, then three rounds of "pick the largest
  // remaining rank, earliest index on ties".
  function automatic exp_t model(input logic [3:0][2:0][7:0] phn,
                                 input logic [3:0][2:0][6:0] q, input bit v);
    exp_t e;
    int   r[12];
    int   rk[12];
    int   p[12];
    bit   picked[12];
    int   best;
    int   d;
    e = '{default: '0};
    e.ov  = v;
    e.chk = v;
    for (int i = 0; i < 12; i++) begin
      r[i] = int'(q[i/3][i%3]);
      p[i] = int'(phn[i/3][i%3]);
      rk[i] = r[i];
      picked[i] = 1'b0;
    end
`ifdef GHOST_CANCEL_EN
    for (int i = 0; i < 12; i++)
      for (int j = 0; j < 12; j++) begin
        d = p[i] - p[j];
        if (d < 0) d = -d;
        if ((i/3 != j/3) && r[i] != 0 && r[j] != 0 && d <= GHOST_WIN &&
            (r[j] > r[i] || (r[j] == r[i] && j/3 < i/3)))
          rk[i] = 0;
      end
`else
    d = GHOST_WIN;
`endif
    for (int k = 0; k < 3; k++) begin
      best = -1;
      for (int i = 0; i < 12; i++)
        if (!picked[i] && (best < 0 || rk[i] > rk[best])) best = i;
      picked[best] = 1'b1;
      if (rk[best] != 0) begin
        e.q[k]  = 7'(rk[best]);
        e.ph[k] = 8'(p[best]);
        e.z[k]  = 2'(best / 3);
        e.s[k]  = 2'(best % 3);
        e.v[k]  = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic exp_t flush_entry();
    exp_t e;
    e = '{default: '0};
    e.chk = 1'b1;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check_eq({cur, ".out_valid"}, 64'(out_valid), 64'(e.ov));
    if (e.chk) begin
      check_eq({cur, ".best_vld"},  64'(best_vld),  64'(e.v));
      check_eq({cur, ".best_q"},    64'(best_q),    64'(e.q));
      check_eq({cur, ".best_ph"},   64'(best_ph),   64'(e.ph));
      check_eq({cur, ".best_zone"}, 64'(best_zone), 64'(e.z));
      check_eq({cur, ".best_slot"}, 64'(best_slot), 64'(e.s));
    end
  endtask

  task automatic step(input bit v);
    exp_t e;
    in_valid = v;
    sb.push_back(model(ph_num, ph_q, v));
    @(posedge clk);
    #1;
    if (sb.size() == 3) begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic clr();
    ph_num = '0;
    ph_q   = '0;
  endtask

  task automatic set(input int z, input int s, input int q, input int ph);
    ph_q[z][s]   = 7'(q);
    ph_num[z][s] = 8'(ph);
  endtask

  task automatic rand_set();
    for (int z = 0; z < 4; z++)
      for (int s = 0; s < 3; s++) begin
        ph_q[z][s]   = ($urandom_range(0, 9) < 3) ? 7'd0 : 7'($urandom_range(1, 127));
        ph_num[z][s] = 8'($urandom_range(0, 40));
      end
  endtask

  // Hold reset for n edges (inputs left live), check the cleared outputs,
  // then expect two all-zero results before the first post-reset set.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    check_eq({cur, ".rst_out_valid"}, 64'(out_valid), 64'd0);
    check_eq({cur, ".rst_best_vld"},  64'(best_vld),  64'd0);
    check_eq({cur, ".rst_best_q"},    64'(best_q),    64'd0);
    check_eq({cur, ".rst_best_ph"},   64'(best_ph),   64'd0);
    check_eq({cur, ".rst_zone_slot"}, 64'({best_zone, best_slot}), 64'd0);
    rst = 1'b0;
    sb.delete();
    sb.push_back(flush_entry());
    sb.push_back(flush_entry());
  endtask

  initial begin
    in_valid = 1'b0;
    clr();
    cur = "reset";
    do_reset(2);

    // Single zone, three ranked candidates; idle neighbours pin the latency.
    cur = "t1";
    step(0);
    set(0, 0, 50, 10); set(0, 1, 40, 50); set(0, 2, 30, 90);
    step(1);
    clr();
    step(0); step(0); step(0);

    // Cross-zone ghost within the window, then just outside it.
    cur = "t2_near";
    set(0, 0, 60, 100); set(1, 0, 55, 103); set(2, 0, 30, 200);
    step(1);
    cur = "t2_far";
    set(1, 0, 55, 105);
    step(1);

    // Equal-rank ghost: lower zone survives.
    cur = "t3";
    clr();
    set(2, 0, 40, 10); set(3, 0, 40, 12);
    step(1);

    // Twelve-way tie resolved by flat index.
    cur = "t4";
    for (int f = 0; f < 12; f++) set(f / 3, f % 3, 20, 20 * f);
    step(1);

    // Empty sector, then only two candidates.
    cur = "t5_empty";
    clr();
    step(1);
    cur = "t5_two";
    set(1, 2, 33, 40); set(3, 1, 7, 200);
    step(1);

    // ph magnitude at the extremes and at the window edge.
    cur = "ph_extreme";
    clr();
    set(0, 0, 10, 0); set(1, 0, 9, 255);
    step(1);
    cur = "ph_win4";
    clr();
    set(0, 0, 10, 0); set(1, 1, 9, 4);
    step(1);
    cur = "ph_win5";
    set(1, 1, 9, 5);
    step(1);

    // Random dense traffic with mixed valid.
    cur = "rand";
    for (int n = 0; n < 40; n++) begin
      rand_set();
      step($urandom_range(0, 9) < 8);
    end

    // Back-to-back sets, reset mid-stream, then fresh sets.
    cur = "midrst_pre";
    for (int n = 0; n < 3; n++) begin
      rand_set();
      step(1);
    end
    rand_set();
    in_valid = 1'b1;
    cur = "midrst";
    do_reset(1);
    cur = "midrst_post";
    clr();
    set(3, 2, 99, 77); set(2, 1, 98, 150);
    step(1);
    for (int n = 0; n < 3; n++) begin
      rand_set();
      step(1);
    end
    clr();
    step(0); step(0); step(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
